// File: rtl/quiz_pkg.sv
// Shared types and default constants for the buzzer round controller.
// The WRONG_PENALTY_EN macro enables score deduction on wrong answers/timeouts.
package quiz_pkg;

    localparam int unsigned MAX_TEAMS        = 8;
    localparam int unsigned TEAM_ID_W        = 3;

    localparam int unsigned DEF_N_TEAMS      = 4;
    localparam int unsigned DEF_DEBOUNCE_CYC = 50_000_000;
    localparam int unsigned DEF_ANSWER_CYC   = 300_000_000;
    localparam int unsigned DEF_SCORE_W      = 8;
    localparam int unsigned DEF_PTS_CORRECT  = 10;
    localparam int unsigned DEF_PTS_WRONG    = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ANSWER = 2'd2
    } state_t;

    typedef logic [TEAM_ID_W-1:0] team_id_t;

    // Index of the lowest set bit; lower team index wins ties.
    function automatic team_id_t lowest_set(input logic [MAX_TEAMS-1:0] v);
        team_id_t r;
        r = '0;
        for (int i = MAX_TEAMS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = team_id_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/press_qualifier.sv
// Debounce counter for one team button; pulses when a press qualifies.
module press_qualifier
    import quiz_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_btn,
    output logic o_qualify_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // Press qualifies on the DEBOUNCE_CYC-th consecutive enabled high sample.
    assign o_qualify_c = i_en & i_btn & (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));

    // Count consecutive enabled high samples; any low sample or clear restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || !(i_en && i_btn)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Buzzer round controller: arms a question, grants the first qualified team,
// times the answer window, applies verdicts to scores and manages lockouts.
// Optional macro WRONG_PENALTY_EN: deduct PTS_WRONG (floored at 0) on a wrong
// answer or timeout; without it only the lockout applies.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int unsigned N_TEAMS      = DEF_N_TEAMS,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned ANSWER_CYC   = DEF_ANSWER_CYC,
    parameter int unsigned SCORE_W      = DEF_SCORE_W,
    parameter int unsigned PTS_CORRECT  = DEF_PTS_CORRECT
`ifdef WRONG_PENALTY_EN
    ,
    parameter int unsigned PTS_WRONG    = DEF_PTS_WRONG
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         clr_scores,
    input  logic [N_TEAMS-1:0]           team_btn,
    input  logic                         judge_ok,
    input  logic                         judge_bad,
    output logic                         armed,
    output logic                         winner_valid,
    output logic [$clog2(N_TEAMS)-1:0]   winner_id,
    output logic [N_TEAMS-1:0]           led,
    output logic [N_TEAMS-1:0]           locked,
    output logic [N_TEAMS*SCORE_W-1:0]   scores
);

    localparam int unsigned ID_W  = $clog2(N_TEAMS);
    localparam int unsigned TMR_W = $clog2(ANSWER_CYC + 1);
    localparam int unsigned SUM_W = SCORE_W + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t              r_state;
    logic                r_armed;
    logic                r_winner_valid;
    logic [ID_W-1:0]     r_winner_id;
    logic [N_TEAMS-1:0]  r_led;
    logic [N_TEAMS-1:0]  r_locked;
    logic [TMR_W-1:0]    r_timer;
    logic [SCORE_W-1:0]  r_scores [N_TEAMS];

    logic [N_TEAMS-1:0]  w_qual;
    logic                w_grant;
    logic                w_in_armed;
    logic                w_in_answer;
    logic                w_ok;
    logic                w_bad;
    logic                w_timeout;
    logic                w_wrong;
    logic [N_TEAMS-1:0]  w_lock_next;
    logic                w_all_locked;
    logic [SCORE_W-1:0]  w_win_score;
    logic [SUM_W-1:0]    w_sum;
    logic [SCORE_W-1:0]  w_add_score;
    logic [SCORE_W-1:0]  w_wrong_score;

    assign w_in_armed  = (r_state == ARMED);
    assign w_in_answer = (r_state == ANSWER);

    // One debounce qualifier per team, enabled only while armed and unlocked.
    for (genvar g = 0; g < N_TEAMS; g++) begin : g_qual
        press_qualifier #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_qual (
            .clk         (clk),
            .rst         (rst),
            .i_en        (w_in_armed & ~r_locked[g]),
            .i_clr       (w_grant),
            .i_btn       (team_btn[g]),
            .o_qualify_c (w_qual[g])
        );
    end

    assign w_grant = w_in_armed & (|w_qual);

    // Verdict decode: simultaneous verdicts cancel; a verdict beats the timeout.
    assign w_ok         = w_in_answer & judge_ok & ~judge_bad;
    assign w_bad        = w_in_answer & judge_bad & ~judge_ok;
    assign w_timeout    = w_in_answer & ~w_ok & ~w_bad & (r_timer == TMR_W'(ANSWER_CYC - 1));
    assign w_wrong      = w_bad | w_timeout;
    assign w_lock_next  = r_locked | r_led;
    assign w_all_locked = &w_lock_next;

    // Select the current winner's score.
    always_comb begin
        w_win_score = '0;
        for (int i = 0; i < N_TEAMS; i++) begin
            if (r_winner_id == ID_W'(i)) begin
                w_win_score = r_scores[i];
            end
        end
    end

    // Saturating add for a correct answer.
    assign w_sum       = {1'b0, w_win_score} + SUM_W'(PTS_CORRECT);
    assign w_add_score = w_sum[SCORE_W] ? SCORE_MAX : w_sum[SCORE_W-1:0];

`ifdef WRONG_PENALTY_EN
    // Floored subtract for a wrong answer or timeout.
    assign w_wrong_score = (w_win_score >= SCORE_W'(PTS_WRONG)) ?
                           (w_win_score - SCORE_W'(PTS_WRONG)) : '0;
`else
    // No deduction: the score is kept as-is.
    assign w_wrong_score = w_win_score;
`endif

    // Round FSM with registered status outputs, timer and lockout mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_armed        <= 1'b0;
            r_winner_valid <= 1'b0;
            r_winner_id    <= '0;
            r_led          <= '0;
            r_locked       <= '0;
            r_timer        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= ARMED;
                        r_armed  <= 1'b1;
                        r_locked <= '0;
                    end
                end
                ARMED: begin
                    if (w_grant) begin
                        r_state        <= ANSWER;
                        r_armed        <= 1'b0;
                        r_winner_valid <= 1'b1;
                        r_winner_id    <= ID_W'(lowest_set(MAX_TEAMS'(w_qual)));
                        r_led          <= N_TEAMS'(1) << lowest_set(MAX_TEAMS'(w_qual));
                        r_timer        <= '0;
                    end
                end
                ANSWER: begin
                    r_timer <= r_timer + TMR_W'(1);
                    if (w_ok) begin
                        r_state        <= IDLE;
                        r_winner_valid <= 1'b0;
                        r_led          <= '0;
                        r_locked       <= '0;
                    end else if (w_wrong) begin
                        r_winner_valid <= 1'b0;
                        r_led          <= '0;
                        if (w_all_locked) begin
                            r_state  <= IDLE;
                            r_locked <= '0;
                        end else begin
                            r_state  <= ARMED;
                            r_armed  <= 1'b1;
                            r_locked <= w_lock_next;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Score registers: clear in IDLE, verdict updates for the winner in ANSWER.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_TEAMS; i++) begin
                r_scores[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_TEAMS; i++) begin
                if (r_state == IDLE && clr_scores) begin
                    r_scores[i] <= '0;
                end else if (r_winner_id == ID_W'(i)) begin
                    if (w_ok) begin
                        r_scores[i] <= w_add_score;
                    end else if (w_wrong) begin
                        r_scores[i] <= w_wrong_score;
                    end
                end
            end
        end
    end

    assign armed        = r_armed;
    assign winner_valid = r_winner_valid;
    assign winner_id    = r_winner_id;
    assign led          = r_led;
    assign locked       = r_locked;

    for (genvar g = 0; g < N_TEAMS; g++) begin : g_scores
        assign scores[g*SCORE_W +: SCORE_W] = r_scores[g];
    end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl: a round-level reference model predicts
// arm / grant / close events; a monitor pops and compares them as they appear.
module tb_quiz_round_ctrl;

    localparam int N       = 4;
    localparam int DEB     = 4;
    localparam int ANS     = 20;
    localparam int SW      = 8;
    localparam int PTS_OK  = 10;
    localparam int PTS_BAD = 5;
    localparam int SMAX    = (1 << SW) - 1;

    localparam int EV_ARM   = 0;
    localparam int EV_GRANT = 1;
    localparam int EV_CLOSE = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              clr_scores = 1'b0;
    logic [N-1:0]      team_btn = '0;
    logic              judge_ok = 1'b0;
    logic              judge_bad = 1'b0;
    logic              armed;
    logic              winner_valid;
    logic [1:0]        winner_id;
    logic [N-1:0]      led;
    logic [N-1:0]      locked;
    logic [N*SW-1:0]   scores;

    quiz_round_ctrl #(
        .N_TEAMS      (N),
        .DEBOUNCE_CYC (DEB),
        .ANSWER_CYC   (ANS),
        .SCORE_W      (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clr_scores   (clr_scores),
        .team_btn     (team_btn),
        .judge_ok     (judge_ok),
        .judge_bad    (judge_bad),
        .armed        (armed),
        .winner_valid (winner_valid),
        .winner_id    (winner_id),
        .led          (led),
        .locked       (locked),
        .scores       (scores)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int            kind;
        int            cyc;
        int            id;
        logic [N*SW-1:0] sc;
        logic [N-1:0]  lk;
        logic          arm;
    } ev_t;

    ev_t q[$];

    // Reference model state
    typedef enum int {M_IDLE, M_ARMED, M_ANSWER} mst_t;
    mst_t       m_st = M_IDLE;
    int         m_streak [N];
    int         m_score  [N];
    bit [N-1:0] m_lock = '0;
    int         m_win = 0;
    int         m_timer = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*SW-1:0] pack_scores();
        logic [N*SW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*SW +: SW] = SW'(m_score[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE;
        m_lock = '0;
        m_win = 0;
        m_timer = 0;
        for (int i = 0; i < N; i++) begin
            m_streak[i] = 0;
            m_score[i] = 0;
        end
    endtask

    // Predict the effect of the next clock edge given the inputs now applied.
    task automatic model_step(input bit s, input bit c, input logic [N-1:0] b,
                              input bit ok, input bit bad);
        ev_t e;
        int  w;
        bit  v_ok, v_bad, v_to;
        e.kind = 0; e.cyc = edge_cnt + 1; e.id = 0; e.sc = '0; e.lk = '0; e.arm = 1'b0;
        case (m_st)
            M_IDLE: begin
                if (c) for (int i = 0; i < N; i++) m_score[i] = 0;
                if (s) begin
                    m_st = M_ARMED;
                    m_lock = '0;
                    e.kind = EV_ARM; e.sc = pack_scores(); e.lk = m_lock;
                    q.push_back(e);
                end
            end
            M_ARMED: begin
                w = -1;
                for (int i = 0; i < N; i++)
                    m_streak[i] = (b[i] && !m_lock[i]) ? m_streak[i] + 1 : 0;
                for (int i = N - 1; i >= 0; i--)
                    if (m_streak[i] == DEB) w = i;
                if (w >= 0) begin
                    m_win = w;
                    m_st = M_ANSWER;
                    m_timer = 0;
                    for (int i = 0; i < N; i++) m_streak[i] = 0;
                    e.kind = EV_GRANT; e.id = w;
                    q.push_back(e);
                end
            end
            default: begin
                v_ok  = ok && !bad;
                v_bad = bad && !ok;
                v_to  = !v_ok && !v_bad && (m_timer == ANS - 1);
                m_timer++;
                if (v_ok) begin
                    m_score[m_win] = (m_score[m_win] + PTS_OK > SMAX) ? SMAX : m_score[m_win] + PTS_OK;
                    m_lock = '0;
                    m_st = M_IDLE;
                end else if (v_bad || v_to) begin
`ifdef WRONG_PENALTY_EN
                    m_score[m_win] = (m_score[m_win] >= PTS_BAD) ? m_score[m_win] - PTS_BAD : 0;
`endif
                    m_lock[m_win] = 1'b1;
                    if (&m_lock) begin
                        m_lock = '0;
                        m_st = M_IDLE;
                    end else begin
                        m_st = M_ARMED;
                    end
                end
                if (v_ok || v_bad || v_to) begin
                    e.kind = EV_CLOSE; e.sc = pack_scores(); e.lk = m_lock;
                    e.arm = (m_st == M_ARMED);
                    q.push_back(e);
                end
            end
        endcase
    endtask

    // Monitor: compare each DUT-presented event with the oldest prediction.
    task automatic check_event(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, edge_cnt);
            return;
        end
        e = q.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        chk("event_cycle", 64'(edge_cnt), 64'(e.cyc));
        if (kind == EV_GRANT) begin
            chk("grant_winner_id", 64'(winner_id), 64'(e.id));
            chk("grant_led", 64'(led), 64'(N'(1) << e.id));
        end else if (kind == EV_CLOSE) begin
            chk("close_scores", 64'(scores), 64'(e.sc));
            chk("close_locked", 64'(locked), 64'(e.lk));
            chk("close_armed", 64'(armed), 64'(e.arm));
        end else begin
            chk("arm_scores", 64'(scores), 64'(e.sc));
            chk("arm_locked", 64'(locked), 64'(e.lk));
        end
    endtask

    logic p_arm = 1'b0;
    logic p_wv  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            p_arm = armed;
            p_wv  = winner_valid;
        end else begin
            while (q.size() > 0 && q[0].cyc < edge_cnt) begin
                n_cmp++; n_bad++;
                $display("FAIL missed_event: got nothing expected kind %0d at cycle %0d", q[0].kind, q[0].cyc);
                void'(q.pop_front());
            end
            if (winner_valid && !p_wv)       check_event(EV_GRANT);
            else if (!winner_valid && p_wv)  check_event(EV_CLOSE);
            else if (armed && !p_arm && !p_wv) check_event(EV_ARM);
            p_arm = armed;
            p_wv  = winner_valid;
        end
    end

    // Apply one cycle of inputs, predict it, and advance past the edge.
    task automatic cyc(input bit s, input bit c, input logic [N-1:0] b, input bit ok, input bit bad);
        start = s; clr_scores = c; team_btn = b; judge_ok = ok; judge_bad = bad;
        model_step(s, c, b, ok, bad);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, '0, 0, 0);
    endtask

    task automatic press(input logic [N-1:0] b, input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, b, 0, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_armed"}, 64'(armed), 64'd0);
        chk({tag, "_winner_valid"}, 64'(winner_valid), 64'd0);
        chk({tag, "_winner_id"}, 64'(winner_id), 64'd0);
        chk({tag, "_led"}, 64'(led), 64'd0);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
        chk({tag, "_scores"}, 64'(scores), 64'd0);
    endtask

    task automatic do_reset();
        start = 0; clr_scores = 0; team_btn = '0; judge_ok = 0; judge_bad = 0;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] rb;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // Single press by team 2, correct answer
        cyc(1, 0, '0, 0, 0);
        press(4'b0100, 4);
        idle(1);
        cyc(0, 0, '0, 1, 0);
        idle(2);

        // Tie between teams 1 and 3
        cyc(1, 0, '0, 0, 0);
        press(4'b1010, 4);
        cyc(0, 0, '0, 1, 0);
        idle(1);

        // Broken press does not qualify; wrong answer locks team 0 out
        cyc(1, 0, '0, 0, 0);
        press(4'b0001, 3);
        press(4'b0000, 1);
        press(4'b0001, 3);
        press(4'b0001, 1);
        cyc(0, 0, '0, 0, 1);
        press(4'b0001, 6);
        press(4'b0011, 4);
        cyc(0, 0, '0, 1, 0);
        idle(1);

        // Clear scores, then every team times out in turn
        cyc(0, 1, '0, 0, 0);
        cyc(1, 0, '0, 0, 0);
        press(4'b1000, 4); idle(ANS + 1);
        press(4'b0001, 4); idle(ANS + 1);
        press(4'b0010, 4); idle(ANS + 1);
        press(4'b0100, 4); idle(ANS + 2);

        // Simultaneous verdicts are ignored; timer keeps running
        cyc(1, 0, '0, 0, 0);
        press(4'b0100, 4);
        for (int k = 0; k < 3; k++) cyc(0, 0, '0, 1, 1);
        idle(2);
        cyc(0, 0, '0, 1, 0);
        idle(1);

        // Saturation: clear and score team 0 twenty-six times
        cyc(1, 1, '0, 0, 0);
        press(4'b0001, 4);
        cyc(0, 0, '0, 1, 0);
        for (int r = 0; r < 25; r++) begin
            cyc(1, 0, '0, 0, 0);
            press(4'b0001, 4);
            cyc(0, 0, '0, 1, 0);
        end
        idle(1);
        chk("saturated_score0", 64'(scores[SW-1:0]), 64'd255);

        // Reset in the middle of an answer window
        cyc(1, 0, '0, 0, 0);
        press(4'b0010, 4);
        idle(2);
        do_reset();
        idle(2);

        // Randomized rounds
        rb = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0) rb[i] = ~rb[i];
            cyc($urandom_range(5) == 0, $urandom_range(19) == 0, rb,
                $urandom_range(11) == 0, $urandom_range(11) == 0);
        end
        idle(ANS + 4);

        chk("pending_events", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
Round controller and arbiter for the buzzer scoring system.
- Arms a question, debounces the team buttons, and grants the answer to the first team whose press qualifies. Ties go to the lowest team index.
- Runs a timed answer window, applies the host's verdict to per-team scores, and locks out teams that answered wrongly until the question closes.
- Sits between the raw button inputs and the LED/score display logic.

Parameters:
- N_TEAMS, 4: number of teams; 2..8.
- DEBOUNCE_CYC, 50_000_000: consecutive high samples that qualify a press.
- ANSWER_CYC, 300_000_000: answer-window length in cycles.
- SCORE_W, 8: width of each team's score.
- PTS_CORRECT, 10: points added on a correct answer.
- PTS_WRONG, 5: points deducted on a wrong answer or timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  host pulse that arms a new question.
- clr_scores  in  1  zeroes all scores; honoured only in IDLE.
- team_btn  in  N_TEAMS  raw button levels, bit i = team i.
- judge_ok  in  1  host verdict: correct.
- judge_bad  in  1  host verdict: wrong.
- armed  out  1  high in ARMED.
- winner_valid  out  1  high in ANSWER.
- winner_id  out  $clog2(N_TEAMS)  granted team; held until the next grant.
- led  out  N_TEAMS  one-hot of the granted team during ANSWER, else 0.
- locked  out  N_TEAMS  lockout mask.
- scores  out  N_TEAMS*SCORE_W  team i score at [i*SCORE_W +: SCORE_W].

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs are 0, all scores 0, all counters 0.
- IDLE:
  - start -> ARMED on the next edge; locked cleared.
  - clr_scores zeroes the scores. If asserted together with start, both take effect.
- ARMED:
  - Counter i increments each cycle that team_btn[i]=1 and locked[i]=0. It clears to 0 on any low sample.
  - Team i qualifies on the edge where its counter equals DEBOUNCE_CYC-1 with team_btn[i]=1, i.e. the DEBOUNCE_CYC-th consecutive high sample.
  - On that edge: winner_id=i, state=ANSWER, all counters cleared, answer timer cleared.
  - Several teams qualifying on the same edge: the lowest index wins. The others get no credit and must re-press.
- ANSWER:
  - Timer increments each cycle.
  - judge_ok alone: winner score += PTS_CORRECT, saturating at 2^SCORE_W-1; locked cleared; -> IDLE.
  - judge_bad alone, or timer reaches ANSWER_CYC-1 with no verdict: penalty applied (see Optional Feature); locked[winner]=1.
    - If every team is now locked: locked cleared, -> IDLE.
    - Otherwise -> ARMED.
  - judge_ok and judge_bad together: ignored; the timer keeps running. A verdict arriving on the timeout edge takes priority over the timeout.
- Ignored inputs: start outside IDLE; verdicts outside ANSWER; clr_scores outside IDLE.
- Buttons held across the ANSWER->ARMED transition restart counting from 0.
- All outputs are registered. Every score update is visible one cycle after the verdict edge.
- Reset asserted mid-round aborts immediately; scores are lost.

Optional Feature:
- Macro: WRONG_PENALTY_EN.
- Defined: a wrong answer or timeout subtracts PTS_WRONG from the winner's score, floored at 0 (no wrap).
- Undefined: no deduction; only the lockout applies and the score path has no subtractor.

Decomposition:
- Package quiz_pkg holds:
  - state enum {IDLE, ARMED, ANSWER};
  - team_id_t typedef;
  - default constants for DEBOUNCE_CYC, ANSWER_CYC, PTS_CORRECT, PTS_WRONG.
- Sub-module press_qualifier, instantiated N_TEAMS times.
  - Contains one debounce counter with enable (ARMED & ~locked[i]) and a synchronous clear.
  - Outputs a one-cycle qualify pulse.
- The top level does the priority pick, FSM, timer and score registers.

Test Plan (all with DEBOUNCE_CYC=4, ANSWER_CYC=20, WRONG_PENALTY_EN defined unless stated):
- start; team 2 held 4 cycles -> winner_valid=1, winner_id=2, led=0100 one cycle after the 4th sample; judge_ok -> scores[2]=10, state IDLE, locked=0.
- start; teams 1 and 3 pressed on the same cycle for 4 cycles -> winner_id=1; team 3 counter cleared.
- start; team 0 high 3 cycles, low 1, high 3 -> no grant; a 4th consecutive high -> grant to team 0.
- Team 0 wins with score 10; judge_bad -> score 5, locked=0001, ARMED. Team 0 holds its button -> never granted. Team 1 presses 4 cycles -> granted.
- Team 3 wins and no verdict for 20 cycles -> timeout; score stays 0 (floor); locked[3]=1. Repeat for all 4 teams -> locked cleared, IDLE. With WRONG_PENALTY_EN undefined, scores are unchanged throughout.
- Reset asserted mid-ANSWER -> led=0, winner_valid=0, scores=0 immediately; judge_ok and judge_bad on the same cycle -> no score change, timer continues; score 250 plus a correct answer -> 255 (saturates).
